// File: rtl/serializador_resultado_if.sv
// serializador_resultado_if
//   Groups the capture handshake and the serial-side outputs of
//   serializador_resultado into one bundle.
//   master : upstream accumulator side (drives i_*, observes o_*)
//   slave  : the serializer itself (observes i_*, drives o_*)
//   Signals:
//     i_data       accumulator value to send (NB_DATA bits)
//     i_overflow   accumulator overflow flag sent with i_data
//     i_valid      capture request
//     o_ready      serializer can accept a word this cycle
//     o_tx         serial line, idle high
//     o_busy       frame in progress
//     o_frame_done one-cycle pulse on the last cycle of the stop bit
//     o_sticky_ovf set by any accepted word carrying overflow
//     i_clr_ovf    synchronous clear of o_sticky_ovf
interface serializador_resultado_if #(
  parameter int NB_DATA = 6
);
  logic [NB_DATA-1:0] i_data;
  logic               i_overflow;
  logic               i_valid;
  logic               o_ready;
  logic               o_tx;
  logic               o_busy;
  logic               o_frame_done;
  logic               o_sticky_ovf;
  logic               i_clr_ovf;

  modport master (
    output i_data, i_overflow, i_valid, i_clr_ovf,
    input  o_ready, o_tx, o_busy, o_frame_done, o_sticky_ovf
  );

  modport slave (
    input  i_data, i_overflow, i_valid, i_clr_ovf,
    output o_ready, o_tx, o_busy, o_frame_done, o_sticky_ovf
  );
endinterface

// File: rtl/serializador_resultado.sv
// serializador_resultado
//   Captures the accumulator value and its overflow flag through a
//   valid/ready handshake and sends them as one framed serial word:
//   start(0) | data LSB first | overflow | even parity | stop(1),
//   each bit held CLKS_PER_BIT cycles. Keeps a sticky overflow flag.
//   Ports:
//     clk   system clock, rising edge
//     i_rst asynchronous active-high reset (aborts any frame in flight)
//     bus   serializador_resultado_if.slave (handshake + serial outputs)
module serializador_resultado #(
  parameter int NB_DATA      = 6,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                    clk,
  input  logic                    i_rst,
  serializador_resultado_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    OVF,
    PARITY,
    STOP
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [IDX_W-1:0]   idx_inc;
  logic               tx, tx_n;
  logic               sticky;
  logic [NB_DATA-1:0] data_q;
  logic               ovf_q;
  logic               par_q;
  logic               accept;
  logic               bit_end;

  function automatic logic even_parity(input logic [NB_DATA-1:0] d,
                                       input logic               ovf);
    return (^d) ^ ovf;
  endfunction

  assign accept  = bus.i_valid && (state == IDLE);
  assign bit_end = (cnt == CNT_LAST);
  assign idx_inc = idx + 1'b1;

  // Captured word: loaded only at the accept edge, held for the whole frame
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= bus.i_data;
      ovf_q  <= bus.i_overflow;
      par_q  <= even_parity(bus.i_data, bus.i_overflow);
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      tx    <= tx_n;
    end
  end

  // Next state; tx_n is the level of the bit that begins on the next cycle,
  // so the registered line changes exactly on bit boundaries.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    tx_n    = tx;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = data_q[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            state_n = OVF;
            tx_n    = ovf_q;
          end else begin
            idx_n = idx_inc;
            tx_n  = data_q[idx_inc];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      OVF: begin
        if (bit_end) begin
          state_n = PARITY;
          cnt_n   = '0;
          tx_n    = par_q;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Sticky overflow: a set at the same edge as a clear takes priority
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sticky <= 1'b0;
    end else if (accept && bus.i_overflow) begin
      sticky <= 1'b1;
    end else if (bus.i_clr_ovf) begin
      sticky <= 1'b0;
    end
  end

  assign bus.o_tx         = tx;
  assign bus.o_ready      = (state == IDLE);
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_frame_done = (state == STOP) && bit_end;
  assign bus.o_sticky_ovf = sticky;

endmodule
